conv_layer_sched: RTL and testbench

CONV_LAYER_SCHED -- requirements
Module: conv_layer_sched

---
 rtl/cnn_pkg.sv | 17 +
 rtl/pass_timer.sv | 32 +++
 rtl/conv_layer_sched.sv | 157 +++++++++++++++
 tb/tb_conv_layer_sched.sv | 284 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cnn_pkg.sv
// Shared types and default sizing for the convolution layer scheduler.
package cnn_pkg;

    localparam int unsigned DEF_MAX_KERNELS    = 8;
    localparam int unsigned DEF_FLUSH_CYCLES   = 3;
    localparam int unsigned DEF_TIMEOUT_CYCLES = 2048;

    typedef enum logic [2:0] {
        IDLE,
        FLUSH,
        RUN,
        STORE,
        NEXT,
        FINISH
    } sched_state_t;

endpackage

// File: rtl/pass_timer.sv
// Loadable down-counter with a registered expired flag; shared by flush and timeout timing.
module pass_timer #(
    parameter int unsigned WIDTH = 12
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load_i,
    input  logic [WIDTH-1:0] load_val_i,
    input  logic             en_i,
    output logic             expired_o
);

    logic [WIDTH-1:0] count_q;
    logic             expired_q;

    // Expired is tracked alongside the count so it is available as a flop output.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_q   <= '0;
            expired_q <= 1'b0;
        end else if (load_i) begin
            count_q   <= load_val_i;
            expired_q <= (load_val_i == '0);
        end else if (en_i && (count_q != '0)) begin
            count_q   <= count_q - WIDTH'(1);
            expired_q <= (count_q == WIDTH'(1));
        end
    end

    assign expired_o = expired_q;

endmodule

// File: rtl/conv_layer_sched.sv
// Layer scheduler: sequences flush / run / store passes of a convolution engine per kernel.
module conv_layer_sched
    import cnn_pkg::*;
#(
    parameter int unsigned MAX_KERNELS    = DEF_MAX_KERNELS,
    parameter int unsigned FLUSH_CYCLES   = DEF_FLUSH_CYCLES,
    parameter int unsigned TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           start,
    input  logic [$clog2(MAX_KERNELS):0]   num_kernels,
    input  logic                           abort,
    input  logic                           eng_done,
    output logic                           eng_rst_n,
    output logic [$clog2(MAX_KERNELS)-1:0] ker_sel,
    output logic                           fmap_wr,
    output logic                           busy,
    output logic                           done,
    output logic                           err
);

    localparam int unsigned KS_W    = $clog2(MAX_KERNELS);
    localparam int unsigned NK_W    = KS_W + 1;
    localparam int unsigned TMR_MAX = (TIMEOUT_CYCLES > FLUSH_CYCLES) ? TIMEOUT_CYCLES : FLUSH_CYCLES;
    localparam int unsigned TMR_W   = $clog2(TMR_MAX + 1);

    sched_state_t    state_q, state_d;
    logic [NK_W-1:0] count_q;
    logic [KS_W-1:0] ker_sel_q;
    logic            done_prev_q;
    logic            eng_rst_n_q;
    logic            fmap_wr_q;
    logic            busy_q;
    logic            done_q;
    logic            err_q;

    logic             cfg_ok;
    logic             accept;
    logic             eng_rise;
    logic             last_pass;
    logic             set_err;
    logic             tmr_load;
    logic [TMR_W-1:0] tmr_val;
    logic             tmr_en;
    logic             tmr_expired;

    assign cfg_ok    = (num_kernels != '0) && (num_kernels <= NK_W'(MAX_KERNELS));
    assign accept    = (state_q == IDLE) && start && cfg_ok;
    assign eng_rise  = eng_done && !done_prev_q;
    assign last_pass = ({1'b0, ker_sel_q} == (count_q - NK_W'(1)));
    assign tmr_en    = (state_q == FLUSH) || (state_q == RUN);

    pass_timer #(
        .WIDTH (TMR_W)
    ) u_pass_timer (
        .clk        (clk),
        .rst        (rst),
        .load_i     (tmr_load),
        .load_val_i (tmr_val),
        .en_i       (tmr_en),
        .expired_o  (tmr_expired)
    );

    // Next-state and timer control; abort overrides everything outside IDLE.
    always_comb begin
        state_d  = state_q;
        set_err  = 1'b0;
        tmr_load = 1'b0;
        tmr_val  = '0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    if (cfg_ok) begin
                        state_d  = FLUSH;
                        tmr_load = 1'b1;
                        tmr_val  = TMR_W'(FLUSH_CYCLES - 1);
                    end else begin
                        set_err = 1'b1;
                    end
                end
            end
            FLUSH: begin
                if (tmr_expired) begin
                    state_d  = RUN;
                    tmr_load = 1'b1;
                    tmr_val  = TMR_W'(TIMEOUT_CYCLES - 1);
                end
            end
            RUN: begin
                if (eng_rise) begin
                    state_d = STORE;
                end else if (tmr_expired) begin
                    state_d = IDLE;
                    set_err = 1'b1;
                end
            end
            STORE: state_d = NEXT;
            NEXT: begin
                if (last_pass) begin
                    state_d = FINISH;
                end else begin
                    state_d  = FLUSH;
                    tmr_load = 1'b1;
                    tmr_val  = TMR_W'(FLUSH_CYCLES - 1);
                end
            end
            FINISH:  state_d = IDLE;
            default: state_d = IDLE;
        endcase
        if (abort && (state_q != IDLE)) begin
            state_d  = IDLE;
            set_err  = 1'b0;
            tmr_load = 1'b0;
        end
    end

    // State, pass bookkeeping and outputs decoded from the upcoming state.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            count_q     <= '0;
            ker_sel_q   <= '0;
            done_prev_q <= 1'b0;
            eng_rst_n_q <= 1'b0;
            fmap_wr_q   <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            done_prev_q <= eng_done;
            eng_rst_n_q <= (state_d == RUN) || (state_d == STORE);
            fmap_wr_q   <= (state_d == STORE);
            busy_q      <= (state_d != IDLE);
            done_q      <= (state_d == FINISH);
            if (accept) begin
                count_q   <= num_kernels;
                ker_sel_q <= '0;
                err_q     <= 1'b0;
            end else if (set_err) begin
                err_q <= 1'b1;
            end
            if ((state_q == NEXT) && (state_d == FLUSH)) begin
                ker_sel_q <= ker_sel_q + KS_W'(1);
            end
        end
    end

    assign eng_rst_n = eng_rst_n_q;
    assign ker_sel   = ker_sel_q;
    assign fmap_wr   = fmap_wr_q;
    assign busy      = busy_q;
    assign done      = done_q;
    assign err       = err_q;

endmodule

// File: tb/tb_conv_layer_sched.sv
// Bench for conv_layer_sched: period-based pass model plus directed abort/timeout/reset cases.
module tb_conv_layer_sched;

    localparam int F = 3;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       start = 1'b0;
    logic [3:0] num_kernels = 4'd0;
    logic       abort = 1'b0;
    logic       eng_force = 1'b0;
    logic       eng_auto = 1'b0;
    logic       eng_done;
    logic       eng_rst_n;
    logic [2:0] ker_sel;
    logic       fmap_wr, busy, done, err;

    logic       start_to = 1'b0;
    logic [3:0] num_to = 4'd1;
    logic       abort_to = 1'b0;
    logic       eng_done_to = 1'b0;
    logic       eng_rst_n_to;
    logic [2:0] ker_sel_to;
    logic       fmap_wr_to, busy_to, done_to, err_to;

    assign eng_done = eng_auto | eng_force;

    always #5 clk = ~clk;

    conv_layer_sched dut (
        .clk(clk), .rst(rst), .start(start), .num_kernels(num_kernels), .abort(abort),
        .eng_done(eng_done), .eng_rst_n(eng_rst_n), .ker_sel(ker_sel), .fmap_wr(fmap_wr),
        .busy(busy), .done(done), .err(err)
    );

    conv_layer_sched #(.TIMEOUT_CYCLES(64)) dut_to (
        .clk(clk), .rst(rst), .start(start_to), .num_kernels(num_to), .abort(abort_to),
        .eng_done(eng_done_to), .eng_rst_n(eng_rst_n_to), .ker_sel(ker_sel_to), .fmap_wr(fmap_wr_to),
        .busy(busy_to), .done(done_to), .err(err_to)
    );

    int n_vec = 0;
    int n_err = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Engine: raises eng_done eng_p cycles after leaving reset (eng_p=0 means never).
    int eng_p = 0;
    int eng_cnt = 0;
    always @(negedge clk) begin
        if (eng_rst_n !== 1'b1) begin
            eng_cnt  = 0;
            eng_auto = 1'b0;
        end else begin
            eng_cnt++;
            if (eng_p != 0 && eng_cnt >= eng_p) eng_auto = 1'b1;
        end
    end

    int cyc = 0;
    always @(posedge clk) cyc++;

    // Output event monitor; read by the main thread only just after a rising edge.
    int fmap_cnt = 0;
    int done_cnt = 0;
    int done_cyc = 0;
    int ksel_log[$];
    always @(negedge clk) begin
        if (fmap_wr === 1'b1) begin
            fmap_cnt++;
            ksel_log.push_back(int'(ker_sel));
        end
        if (done === 1'b1) begin
            done_cnt++;
            done_cyc = cyc;
        end
    end

    // Model: after an accepted start, cycle t (t=1 first) lies in pass (t-1)/period with
    // phases flush(F) / run(P) / store(1) / next(1); a finish cycle follows the last pass.
    bit model_en = 1'b0;
    int m_n = 0, m_p = 0, m_c0 = 0;
    always @(negedge clk) begin
        if (model_en) begin
            int t, per, pass, ph;
            logic [2:0] e_ks;
            logic e_busy, e_rst, e_wr, e_done;
            t   = cyc - m_c0;
            per = F + m_p + 2;
            if (t <= m_n * per) begin
                pass   = (t - 1) / per;
                ph     = (t - 1) % per;
                e_busy = 1'b1;
                e_ks   = 3'(pass);
                e_rst  = (ph >= F) && (ph <= F + m_p);
                e_wr   = (ph == F + m_p);
                e_done = 1'b0;
            end else begin
                e_busy = (t == m_n * per + 1);
                e_done = e_busy;
                e_rst  = 1'b0;
                e_wr   = 1'b0;
                e_ks   = 3'(m_n - 1);
            end
            check("model_busy", 32'(busy), 32'(e_busy));
            check("model_eng_rst_n", 32'(eng_rst_n), 32'(e_rst));
            check("model_ker_sel", 32'(ker_sel), 32'(e_ks));
            check("model_fmap_wr", 32'(fmap_wr), 32'(e_wr));
            check("model_done", 32'(done), 32'(e_done));
            check("model_err", 32'(err), 32'd0);
        end
    end

    task automatic accept_start(input int n);
        @(negedge clk);
        start       = 1'b1;
        num_kernels = 4'(n);
        m_c0        = cyc;
        @(posedge clk);
        #1 start = 1'b0;
    endtask

    task automatic run_layer(input int n, input int p, input int inject_at, input int exp_done_t);
        int f0, d0, q0;
        eng_p = p;
        m_n   = n;
        m_p   = p;
        f0 = fmap_cnt;
        d0 = done_cnt;
        q0 = ksel_log.size();
        accept_start(n);
        model_en = 1'b1;
        for (int k = 1; k <= n * (F + p + 2) + 3; k++) begin
            @(negedge clk);
            start = (k == inject_at);
            if (k == inject_at) num_kernels = 4'd3;
        end
        @(posedge clk);
        #1 model_en = 1'b0;
        start = 1'b0;
        check("run_fmap_count", 32'(fmap_cnt - f0), 32'(n));
        check("run_done_count", 32'(done_cnt - d0), 32'd1);
        check("run_done_latency", 32'(done_cyc - m_c0), 32'(exp_done_t));
        for (int i = 0; i < n; i++) check("run_ker_seq", 32'(ksel_log[q0 + i]), 32'(i));
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int f0, d0, k_err;
        logic wr_seen;

        #1 rst = 1'b1;
        repeat (3) @(negedge clk);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_eng_rst_n", 32'(eng_rst_n), 32'd0);
        check("rst_ker_sel", 32'(ker_sel), 32'd0);
        check("rst_fmap_wr", 32'(fmap_wr), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_err", 32'(err), 32'd0);
        rst = 1'b0;
        repeat (2) @(negedge clk);

        // Bad configurations: err set, never busy, no done.
        d0 = done_cnt;
        accept_start(0);
        check("bad0_err", 32'(err), 32'd1);
        check("bad0_busy", 32'(busy), 32'd0);
        repeat (4) @(negedge clk);
        check("bad0_busy_later", 32'(busy), 32'd0);
        accept_start(9);
        check("bad9_err", 32'(err), 32'd1);
        check("bad9_busy", 32'(busy), 32'd0);
        repeat (4) @(negedge clk);
        check("bad9_busy_later", 32'(busy), 32'd0);
        @(posedge clk); #1;
        check("bad_done_count", 32'(done_cnt - d0), 32'd0);

        // Normal runs; the model also confirms err was cleared by the accepted start.
        run_layer(3, 100, 0, 316);
        run_layer(1, 5, 0, 11);
        run_layer(8, 2, 10, 57);

        // Abort during the run phase of pass 1 of 4.
        eng_p = 20;
        f0 = fmap_cnt;
        d0 = done_cnt;
        accept_start(4);
        repeat (34) @(negedge clk);
        check("abort_pre_ker_sel", 32'(ker_sel), 32'd1);
        check("abort_pre_eng_rst_n", 32'(eng_rst_n), 32'd1);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        check("abort_busy", 32'(busy), 32'd0);
        check("abort_eng_rst_n", 32'(eng_rst_n), 32'd0);
        check("abort_fmap_wr", 32'(fmap_wr), 32'd0);
        repeat (40) @(negedge clk);
        @(posedge clk); #1;
        check("abort_fmap_count", 32'(fmap_cnt - f0), 32'd1);
        check("abort_done_count", 32'(done_cnt - d0), 32'd0);
        check("abort_err", 32'(err), 32'd0);

        // Stale eng_done: high before the run phase, must fall and rise to count.
        eng_p = 0;
        eng_force = 1'b1;
        f0 = fmap_cnt;
        d0 = done_cnt;
        accept_start(1);
        repeat (20) @(negedge clk);
        check("stale_eng_rst_n", 32'(eng_rst_n), 32'd1);
        check("stale_busy", 32'(busy), 32'd1);
        @(posedge clk); #1;
        check("stale_no_store", 32'(fmap_cnt - f0), 32'd0);
        @(negedge clk);
        eng_force = 1'b0;
        @(negedge clk);
        eng_force = 1'b1;
        @(negedge clk);
        check("stale_store", 32'(fmap_wr), 32'd1);
        eng_force = 1'b0;
        repeat (5) @(negedge clk);
        @(posedge clk); #1;
        check("stale_fmap_count", 32'(fmap_cnt - f0), 32'd1);
        check("stale_done_count", 32'(done_cnt - d0), 32'd1);

        // Asynchronous reset in the middle of a flush, then a clean two-pass layer.
        eng_p = 10;
        accept_start(2);
        @(negedge clk);
        @(negedge clk);
        check("flush_busy", 32'(busy), 32'd1);
        check("flush_eng_rst_n", 32'(eng_rst_n), 32'd0);
        #2 rst = 1'b1;
        #1;
        check("arst_busy", 32'(busy), 32'd0);
        check("arst_eng_rst_n", 32'(eng_rst_n), 32'd0);
        check("arst_ker_sel", 32'(ker_sel), 32'd0);
        check("arst_done", 32'(done), 32'd0);
        check("arst_err", 32'(err), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        run_layer(2, 10, 0, 31);

        // Timeout on the 64-cycle instance whose engine never completes.
        @(negedge clk);
        start_to = 1'b1;
        @(posedge clk);
        #1 start_to = 1'b0;
        k_err = 0;
        wr_seen = 1'b0;
        for (int k = 1; k <= 200; k++) begin
            @(negedge clk);
            wr_seen = wr_seen | fmap_wr_to;
            if (k == 67) check("to_last_run_cycle", 32'(eng_rst_n_to), 32'd1);
            if (err_to === 1'b1) begin
                k_err = k;
                break;
            end
        end
        check("to_err_cycle", 32'(k_err), 32'd68);
        check("to_busy", 32'(busy_to), 32'd0);
        check("to_eng_rst_n", 32'(eng_rst_n_to), 32'd0);
        check("to_no_fmap_wr", 32'(wr_seen), 32'd0);
        repeat (3) @(negedge clk);
        check("to_err_sticky", 32'(err_to), 32'd1);
        check("to_done", 32'(done_to), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
